// File: rtl/pcileech_sysctl_pkg.sv
// pcileech_sysctl_pkg
// Shared types and constants for the system reset / button sequencer.
//   sysctl_state_t : sequencer states (hold, run, button pressed, reload).
//   SYNC_STAGES    : depth of the flop chain used on every asynchronous input.
//   cntWidth()     : counter width for a terminal count, never less than 1 bit.
// Optional feature macro used by the slice: PCILEECH_SYSCTL_PERST_RST_EN.

package pcileech_sysctl_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_PRESS,
    S_RELOAD
  } sysctl_state_t;

  localparam int SYNC_STAGES = 2;

  // $clog2 of 1 is 0, which would give a zero-width counter, so clamp to 1.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcileech_sysctl_debounce.sv
// pcileech_sysctl_debounce
// Synchroniser plus debounce counter for one active-low mechanical switch.
// A change is accepted only after the synchronised level has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles; raw edge to
// o_stable_n edge is DEBOUNCE_CYCLES+2 cycles.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (presets to released)
//   i_raw_n    : raw switch level, asynchronous, active-low
//   o_stable_n : debounced switch level, active-low

module pcileech_sysctl_debounce
  import pcileech_sysctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw_n,
  output logic o_stable_n
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_synced;

  assign w_synced   = r_sync[SYNC_STAGES-1];
  assign o_stable_n = r_stable;

  // Everything presets to 1 so a switch reads as released out of reset.
  // Any cycle where the synced level agrees with the accepted level
  // restarts the count, so only an unbroken run of differing cycles
  // flips the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '1;
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
      if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= w_synced;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pcileech_sysctl_rst.sv
// pcileech_sysctl_rst
// System reset and button sequencer. Owns the free-running tick counter,
// switch conditioning, the reset hold window after reset or button release,
// the long-press configuration reload request and the power-on LED blink.
// Ports:
//   clk            : system clock, the only clock
//   rst_n          : asynchronous active-low reset
//   user_sw1_n     : raw switch 1, active-low, asynchronous
//   user_sw2_n     : raw switch 2 (reset button), active-low, asynchronous
//   pcie_perst_n   : PCIe PERST#, asynchronous (only used with the macro)
//   rst_sys        : active-high reset to downstream stages
//   rst_cfg_reload : high while a long press is held
//   led_pwronblink : LED invert / power-on blink control
//   tickcount64    : free-running tick counter
// Optional feature: define PCILEECH_SYSCTL_PERST_RST_EN to let a low PERST#
// force the hold state (except while a reload is being requested).

module pcileech_sysctl_rst #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_HOLD_CYCLES = 64,
  parameter int RELOAD_CYCLES   = 500000000,
  parameter int BLINK_BIT       = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        user_sw1_n,
  input  logic        user_sw2_n,
  input  logic        pcie_perst_n,
  output logic        rst_sys,
  output logic        rst_cfg_reload,
  output logic        led_pwronblink,
  output logic [63:0] tickcount64
);

  import pcileech_sysctl_pkg::*;

  localparam int HOLD_W = cntWidth(RST_HOLD_CYCLES);
  localparam int PRESS_W = cntWidth(RELOAD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(RELOAD_CYCLES - 1);

  sysctl_state_t        r_state;
  sysctl_state_t        w_nextState;
  logic [HOLD_W-1:0]    r_holdCnt;
  logic [PRESS_W-1:0]   r_pressCnt;
  logic                 r_rstSys;
  logic                 r_cfgReload;
  logic                 r_led;
  logic [63:0]          r_tick;
  logic                 w_sw1s;
  logic                 w_sw2s;
  logic                 w_perstInRst;
  logic                 w_blink;

  pcileech_sysctl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debSw1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw_n   (user_sw1_n),
    .o_stable_n(w_sw1s)
  );

  pcileech_sysctl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debSw2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw_n   (user_sw2_n),
    .o_stable_n(w_sw2s)
  );

`ifdef PCILEECH_SYSCTL_PERST_RST_EN
  // PERST# is already a clean level from the root complex, so it only
  // needs synchronising, not debouncing. Presets to deasserted.
  logic [SYNC_STAGES-1:0] r_perstSync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perstSync <= '1;
    end else begin
      r_perstSync <= {r_perstSync[SYNC_STAGES-2:0], pcie_perst_n};
    end
  end

  assign w_perstInRst = ~r_perstSync[SYNC_STAGES-1];
`else
  logic w_unusedPerst;
  assign w_unusedPerst = pcie_perst_n;
  assign w_perstInRst  = 1'b0;
`endif

  // Blink runs only for the first 2^(BLINK_BIT+3) ticks after the counter
  // last restarted.
  assign w_blink = r_tick[BLINK_BIT] & (r_tick[63:BLINK_BIT+3] == '0);

  // A button press beats hold expiry, and a release beats the reload
  // threshold. PERST# overrides everything except an active reload request.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_HOLD: begin
        if (!w_sw2s) begin
          w_nextState = S_PRESS;
        end else if (r_holdCnt == HOLD_LAST) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_sw2s) begin
          w_nextState = S_PRESS;
        end
      end
      S_PRESS: begin
        if (w_sw2s) begin
          w_nextState = S_HOLD;
        end else if (r_pressCnt == PRESS_LAST) begin
          w_nextState = S_RELOAD;
        end
      end
      S_RELOAD: begin
        if (w_sw2s) begin
          w_nextState = S_HOLD;
        end
      end
      default: w_nextState = S_HOLD;
    endcase
    if (w_perstInRst && (r_state != S_RELOAD)) begin
      w_nextState = S_HOLD;
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they move on the same edge as the state register and never glitch from
  // the switch inputs. Counters restart on any state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_holdCnt   <= '0;
      r_pressCnt  <= '0;
      r_rstSys    <= 1'b1;
      r_cfgReload <= 1'b0;
      r_led       <= 1'b0;
      r_tick      <= '0;
    end else begin
      r_state <= w_nextState;

      if ((w_nextState != r_state) || w_perstInRst) begin
        r_holdCnt <= '0;
      end else if (r_state == S_HOLD) begin
        r_holdCnt <= r_holdCnt + HOLD_W'(1);
      end

      if (w_nextState != r_state) begin
        r_pressCnt <= '0;
      end else if ((r_state == S_PRESS) && (r_pressCnt != PRESS_LAST)) begin
        r_pressCnt <= r_pressCnt + PRESS_W'(1);
      end

      r_rstSys    <= (w_nextState != S_RUN);
      r_cfgReload <= (w_nextState == S_RELOAD);

      if ((w_nextState == S_PRESS) || (w_nextState == S_RELOAD)) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + 64'd1;
      end

      r_led <= ~w_sw1s ^ w_blink;
    end
  end

  assign rst_sys        = r_rstSys;
  assign rst_cfg_reload = r_cfgReload;
  assign led_pwronblink = r_led;
  assign tickcount64    = r_tick;

endmodule

// File: tb/tb_pcileech_sysctl_rst.sv
// tb_pcileech_sysctl_rst
// Directed bench for pcileech_sysctl_rst with small parameters. Stimulus
// pushes hand-computed expectations tagged with the cycle they apply to; a
// separate monitor pops and compares them on the falling clock edge (or on
// an explicit event for the asynchronous reset check).
// Honours PCILEECH_SYSCTL_PERST_RST_EN for the PERST# scenario.

module tb_pcileech_sysctl_rst;

   localparam int F_RST    = 0;
   localparam int F_RELOAD = 1;
   localparam int F_TICK   = 2;
   localparam int F_LED    = 3;

   typedef struct {
      int          cyc;
      int          field;
      logic [63:0] expVal;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        user_sw1_n = 1'b1;
   logic        user_sw2_n = 1'b1;
   logic        pcie_perst_n = 1'b1;
   logic        rst_sys;
   logic        rst_cfg_reload;
   logic        led_pwronblink;
   logic [63:0] tickcount64;

   int    cyc = 0;
   int    checkCount = 0;
   int    passCount = 0;
   item_t sb[$];
   event  asyncEv;

   pcileech_sysctl_rst #(
      .DEBOUNCE_CYCLES(4),
      .RST_HOLD_CYCLES(8),
      .RELOAD_CYCLES  (50),
      .BLINK_BIT      (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .user_sw1_n    (user_sw1_n),
      .user_sw2_n    (user_sw2_n),
      .pcie_perst_n  (pcie_perst_n),
      .rst_sys       (rst_sys),
      .rst_cfg_reload(rst_cfg_reload),
      .led_pwronblink(led_pwronblink),
      .tickcount64   (tickcount64)
   );

   // Free-running clock and edge counter used to time-stamp expectations.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string fieldName(input int f);
      case (f)
         F_RST:    return "rst_sys";
         F_RELOAD: return "rst_cfg_reload";
         F_TICK:   return "tickcount64";
         default:  return "led_pwronblink";
      endcase
   endfunction

   // Queue one expectation; pushes must arrive in non-decreasing cycle order.
   task automatic checkOutput(input int atCyc, input int field, input logic [63:0] val);
      item_t it;
      it.cyc    = atCyc;
      it.field  = field;
      it.expVal = val;
      sb.push_back(it);
   endtask

   task automatic stepTo(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the raw inputs just after the posedge that ends cycle atCyc.
   task automatic applyStimulus(input int atCyc, input logic sw1, input logic sw2,
                                input logic perst);
      stepTo(atCyc);
      user_sw1_n   = sw1;
      user_sw2_n   = sw2;
      pcie_perst_n = perst;
   endtask

   // Monitor: compares every expectation whose cycle has been reached.
   initial begin
      item_t       it;
      logic [63:0] act;
      forever begin
         @(negedge clk or asyncEv);
         while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            it = sb.pop_front();
            case (it.field)
               F_RST:    act = {63'd0, rst_sys};
               F_RELOAD: act = {63'd0, rst_cfg_reload};
               F_TICK:   act = tickcount64;
               default:  act = {63'd0, led_pwronblink};
            endcase
            checkCount++;
            if (act === it.expVal) begin
               passCount++;
            end else begin
               $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d",
                        fieldName(it.field), it.cyc, act, it.expVal);
            end
         end
      end
   end

   // Main stimulus sequence with direct checks at the reset points.
   initial begin
      int base;
      int e;
      int p;
      int q;
      int t;
      int r0;
      int b2;
      int s;

      checkOutput(2, F_RST, 64'd1);
      checkOutput(2, F_RELOAD, 64'd0);
      checkOutput(2, F_TICK, 64'd0);
      checkOutput(2, F_LED, 64'd0);
      stepTo(3);
      base = cyc;

      checkCount++;
      if (rst_sys === 1'b1) begin
         passCount++;
      end else begin
         $display("[TB] FAIL rst_sys during reset: got %0b, expected 1", rst_sys);
      end

      for (int k = 0; k <= 13; k++) begin
         checkOutput(base + k, F_RST, (k < 8) ? 64'd1 : 64'd0);
         checkOutput(base + k, F_TICK, 64'(k));
         if (k == 4 || k == 9)  checkOutput(base + k, F_LED, 64'd0);
         if (k == 5 || k == 13) checkOutput(base + k, F_LED, 64'd1);
      end
      checkOutput(base + 10, F_RELOAD, 64'd0);
      #2 rst_n = 1'b1;

      e = base + 20;
      for (int k = 1; k <= 12; k++) begin
         checkOutput(e + k, F_RST, 64'd0);
         checkOutput(e + k, F_TICK, 64'(e + k - base));
      end
      applyStimulus(e, 1'b1, 1'b0, 1'b1);
      applyStimulus(e + 3, 1'b1, 1'b1, 1'b1);

      p = base + 40;
      checkOutput(p + 6, F_RST, 64'd0);
      checkOutput(p + 6, F_TICK, 64'(p + 6 - base));
      checkOutput(p + 7, F_RST, 64'd1);
      checkOutput(p + 7, F_TICK, 64'd0);
      checkOutput(p + 20, F_TICK, 64'd0);
      checkOutput(p + 20, F_RELOAD, 64'd0);
      checkOutput(p + 26, F_RELOAD, 64'd0);
      checkOutput(p + 26, F_TICK, 64'd0);
      checkOutput(p + 27, F_RST, 64'd1);
      checkOutput(p + 27, F_TICK, 64'd1);
      checkOutput(p + 34, F_RST, 64'd1);
      checkOutput(p + 35, F_RST, 64'd0);
      checkOutput(p + 35, F_TICK, 64'd9);
      applyStimulus(p, 1'b1, 1'b0, 1'b1);
      applyStimulus(p + 20, 1'b1, 1'b1, 1'b1);

      q = base + 80;
      checkOutput(q + 7, F_RST, 64'd1);
      checkOutput(q + 7, F_TICK, 64'd0);
      checkOutput(q + 56, F_RELOAD, 64'd0);
      checkOutput(q + 57, F_RELOAD, 64'd1);
      checkOutput(q + 57, F_RST, 64'd1);
      checkOutput(q + 106, F_RELOAD, 64'd1);
      checkOutput(q + 106, F_TICK, 64'd0);
      checkOutput(q + 107, F_RELOAD, 64'd0);
      checkOutput(q + 107, F_RST, 64'd1);
      checkOutput(q + 107, F_TICK, 64'd1);
      checkOutput(q + 114, F_RST, 64'd1);
      checkOutput(q + 115, F_RST, 64'd0);
      checkOutput(q + 115, F_TICK, 64'd9);
      applyStimulus(q, 1'b1, 1'b0, 1'b1);
      applyStimulus(q + 100, 1'b1, 1'b1, 1'b1);

      t = q + 150;
      checkOutput(t + 6, F_LED, 64'd0);
      checkOutput(t + 7, F_LED, 64'd1);
      checkOutput(t + 7, F_TICK, 64'd51);
      checkOutput(t + 16, F_LED, 64'd1);
      checkOutput(t + 17, F_LED, 64'd0);
      applyStimulus(t, 1'b0, 1'b1, 1'b1);
      applyStimulus(t + 10, 1'b1, 1'b1, 1'b1);

      r0 = t + 30;
      checkOutput(r0 + 57, F_RELOAD, 64'd1);
      applyStimulus(r0, 1'b1, 1'b0, 1'b1);
      stepTo(r0 + 60);
      #1 rst_n = 1'b0;
      user_sw2_n = 1'b1;
      #1;

      checkCount++;
      if (rst_cfg_reload === 1'b0) begin
         passCount++;
      end else begin
         $display("[TB] FAIL rst_cfg_reload after async reset: got %0b, expected 0",
                  rst_cfg_reload);
      end
      checkCount++;
      if (rst_sys === 1'b1) begin
         passCount++;
      end else begin
         $display("[TB] FAIL rst_sys after async reset: got %0b, expected 1", rst_sys);
      end
      checkCount++;
      if (tickcount64 === 64'd0) begin
         passCount++;
      end else begin
         $display("[TB] FAIL tickcount64 after async reset: got %0d, expected 0",
                  tickcount64);
      end

      checkOutput(cyc, F_RELOAD, 64'd0);
      checkOutput(cyc, F_RST, 64'd1);
      checkOutput(cyc, F_TICK, 64'd0);
      checkOutput(cyc, F_LED, 64'd0);
      -> asyncEv;

      stepTo(r0 + 63);
      b2 = cyc;
      checkOutput(b2 + 7, F_RST, 64'd1);
      checkOutput(b2 + 8, F_RST, 64'd0);
      checkOutput(b2 + 8, F_TICK, 64'd8);
      #1 rst_n = 1'b1;

      s = b2 + 20;
`ifdef PCILEECH_SYSCTL_PERST_RST_EN
      checkOutput(s + 2, F_RST, 64'd0);
      checkOutput(s + 3, F_RST, 64'd1);
      checkOutput(s + 12, F_RST, 64'd1);
      checkOutput(s + 19, F_RST, 64'd1);
      checkOutput(s + 20, F_RST, 64'd0);
`else
      checkOutput(s + 3, F_RST, 64'd0);
      checkOutput(s + 12, F_RST, 64'd0);
      checkOutput(s + 20, F_RST, 64'd0);
`endif
      checkOutput(s + 20, F_TICK, 64'(s + 20 - b2));
      applyStimulus(s, 1'b1, 1'b1, 1'b0);
      applyStimulus(s + 10, 1'b1, 1'b1, 1'b1);

      stepTo(s + 30);
      while (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         checkCount++;
         $display("[TB] FAIL %s @cyc %0d: never compared, expected %0d",
                  fieldName(it.field), it.cyc, it.expVal);
      end
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
